// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, iterative unsigned mul/div unit, and the EX/MEM register.
// Mul/div holds the front end for MD_CYCLES+1 cycles; the result enters EX/MEM on the DONE edge.
module ex_stage #(
  parameter int XLEN      = 32,
  parameter int MD_CYCLES = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  input  logic [4:0]      EX_ALU_OP,
  input  logic [XLEN-1:0] EX_muxA,
  input  logic [XLEN-1:0] EX_muxB,
  input  logic [15:0]     EX_IMMEDIATE,
  input  logic [XLEN-1:0] EX_NEXT_PC,
  input  logic [1:0]      EX_RF_D_SEL,
  input  logic [1:0]      EX_RD_SEL,
  input  logic            EX_DM_WE,
  input  logic            EX_DM_ADDR_SEL,
  input  logic            EX_ret_enable,
  output logic            ex_stall,
  output logic            MEM_valid,
  output logic [XLEN-1:0] MEM_ALU_RESULT,
  output logic [XLEN-1:0] MEM_DM_ADDR,
  output logic [XLEN-1:0] MEM_STORE_DATA,
  output logic [XLEN-1:0] MEM_NEXT_PC,
  output logic [1:0]      MEM_RF_D_SEL,
  output logic [1:0]      MEM_RD_SEL,
  output logic            MEM_DM_WE,
  output logic            MEM_ret_enable
);
  localparam int CW = $clog2(MD_CYCLES);
  localparam int SW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_SLL   = 5'd5;
  localparam logic [4:0] OP_SRL   = 5'd6;
  localparam logic [4:0] OP_SRA   = 5'd7;
  localparam logic [4:0] OP_SLT   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_PASSB = 5'd10;
  localparam logic [4:0] OP_ADDI  = 5'd11;
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_MULHU = 5'd17;
  localparam logic [4:0] OP_DIVU  = 5'd18;
  localparam logic [4:0] OP_REMU  = 5'd19;

  typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} md_state_t;

  md_state_t         state_q, state_d;
  logic [CW-1:0]     count_q, count_d;
  logic [4:0]        md_op_q, md_op_d;
  logic [2*XLEN-1:0] md_acc_q, md_acc_d;
  logic [2*XLEN-1:0] md_a_q, md_a_d;
  logic [XLEN-1:0]   md_b_q, md_b_d;

  logic              mem_valid_q, mem_valid_d;
  logic [XLEN-1:0]   mem_res_q, mem_res_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_store_q, mem_store_d;
  logic [XLEN-1:0]   mem_npc_q, mem_npc_d;
  logic [1:0]        mem_rf_d_sel_q, mem_rf_d_sel_d;
  logic [1:0]        mem_rd_sel_q, mem_rd_sel_d;
  logic              mem_dm_we_q, mem_dm_we_d;
  logic              mem_ret_q, mem_ret_d;

  logic              is_md_op;
  logic              md_start;
  logic              md_last;
  logic [SW-1:0]     shamt;
  logic [XLEN-1:0]   imm_sext;
  logic [XLEN-1:0]   alu_res;
  logic [XLEN-1:0]   md_res;
  logic [XLEN-1:0]   ex_res;
  logic [XLEN:0]     rem_shift;
  logic [XLEN:0]     rem_diff;

  assign is_md_op = (EX_ALU_OP[4:2] == 3'b100);
  assign md_start = (state_q == MD_IDLE) && ex_valid && is_md_op;
  assign md_last  = (count_q == CW'(MD_CYCLES - 1));
  assign shamt    = EX_muxB[SW-1:0];
  assign imm_sext = {{(XLEN-16){EX_IMMEDIATE[15]}}, EX_IMMEDIATE};

  always_comb begin
    alu_res = '0;
    case (EX_ALU_OP)
      OP_ADD:   alu_res = EX_muxA + EX_muxB;
      OP_SUB:   alu_res = EX_muxA - EX_muxB;
      OP_AND:   alu_res = EX_muxA & EX_muxB;
      OP_OR:    alu_res = EX_muxA | EX_muxB;
      OP_XOR:   alu_res = EX_muxA ^ EX_muxB;
      OP_SLL:   alu_res = EX_muxA << shamt;
      OP_SRL:   alu_res = EX_muxA >> shamt;
      OP_SRA:   alu_res = $unsigned($signed(EX_muxA) >>> shamt);
      OP_SLT:   alu_res = {{(XLEN-1){1'b0}}, ($signed(EX_muxA) < $signed(EX_muxB))};
      OP_SLTU:  alu_res = {{(XLEN-1){1'b0}}, (EX_muxA < EX_muxB)};
      OP_PASSB: alu_res = EX_muxB;
      OP_ADDI:  alu_res = EX_muxA + imm_sext;
      default:  alu_res = '0;
    endcase
  end

  // Divide keeps the partial remainder in md_acc low half and shifts the dividend/quotient through md_a.
  assign rem_shift = {md_acc_q[XLEN-1:0], md_a_q[XLEN-1]};
  assign rem_diff  = rem_shift - {1'b0, md_b_q};

  always_comb begin
    count_d  = count_q;
    md_op_d  = md_op_q;
    md_acc_d = md_acc_q;
    md_a_d   = md_a_q;
    md_b_d   = md_b_q;
    case (state_q)
      MD_IDLE: begin
        if (md_start) begin
          md_op_d  = EX_ALU_OP;
          md_acc_d = '0;
          md_a_d   = {{XLEN{1'b0}}, EX_muxA};
          md_b_d   = EX_muxB;
          count_d  = '0;
        end
      end
      MD_BUSY: begin
        count_d = md_last ? '0 : count_q + 1'b1;
        if (!md_op_q[1]) begin
          if (md_b_q[0]) md_acc_d = md_acc_q + md_a_q;
          md_a_d = md_a_q << 1;
          md_b_d = md_b_q >> 1;
        end else if (!rem_diff[XLEN]) begin
          md_acc_d = {{XLEN{1'b0}}, rem_diff[XLEN-1:0]};
          md_a_d   = {{XLEN{1'b0}}, md_a_q[XLEN-2:0], 1'b1};
        end else begin
          md_acc_d = {{XLEN{1'b0}}, rem_shift[XLEN-1:0]};
          md_a_d   = {{XLEN{1'b0}}, md_a_q[XLEN-2:0], 1'b0};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    md_res = '0;
    case (md_op_q)
      OP_MUL:   md_res = md_acc_q[XLEN-1:0];
      OP_MULHU: md_res = md_acc_q[2*XLEN-1:XLEN];
      OP_DIVU:  md_res = md_a_q[XLEN-1:0];
      OP_REMU:  md_res = md_acc_q[XLEN-1:0];
      default:  md_res = '0;
    endcase
  end

  assign ex_res = (state_q == MD_DONE) ? md_res : alu_res;

  always_comb begin
    state_d = state_q;
    case (state_q)
      MD_IDLE: if (md_start) state_d = MD_BUSY;
      MD_BUSY: if (md_last) state_d = MD_DONE;
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  always_comb begin
    ex_stall = md_start || (state_q == MD_BUSY);
  end

  always_comb begin
    mem_valid_d    = mem_valid_q;
    mem_res_d      = mem_res_q;
    mem_addr_d     = mem_addr_q;
    mem_store_d    = mem_store_q;
    mem_npc_d      = mem_npc_q;
    mem_rf_d_sel_d = mem_rf_d_sel_q;
    mem_rd_sel_d   = mem_rd_sel_q;
    mem_dm_we_d    = mem_dm_we_q;
    mem_ret_d      = mem_ret_q;
    if (ex_stall) begin
      mem_valid_d = 1'b0;
      mem_dm_we_d = 1'b0;
    end else begin
      mem_valid_d    = ex_valid;
      mem_res_d      = ex_res;
      mem_addr_d     = EX_DM_ADDR_SEL ? {16'h0, EX_IMMEDIATE} : ex_res;
      mem_store_d    = EX_muxB;
      mem_npc_d      = EX_NEXT_PC;
      mem_rf_d_sel_d = EX_RF_D_SEL;
      mem_rd_sel_d   = EX_RD_SEL;
      mem_dm_we_d    = EX_DM_WE;
      mem_ret_d      = EX_ret_enable;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= MD_IDLE;
      count_q  <= '0;
      md_op_q  <= '0;
      md_acc_q <= '0;
      md_a_q   <= '0;
      md_b_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      md_op_q  <= md_op_d;
      md_acc_q <= md_acc_d;
      md_a_q   <= md_a_d;
      md_b_q   <= md_b_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_valid_q    <= 1'b0;
      mem_res_q      <= '0;
      mem_addr_q     <= '0;
      mem_store_q    <= '0;
      mem_npc_q      <= '0;
      mem_rf_d_sel_q <= '0;
      mem_rd_sel_q   <= '0;
      mem_dm_we_q    <= 1'b0;
      mem_ret_q      <= 1'b0;
    end else begin
      mem_valid_q    <= mem_valid_d;
      mem_res_q      <= mem_res_d;
      mem_addr_q     <= mem_addr_d;
      mem_store_q    <= mem_store_d;
      mem_npc_q      <= mem_npc_d;
      mem_rf_d_sel_q <= mem_rf_d_sel_d;
      mem_rd_sel_q   <= mem_rd_sel_d;
      mem_dm_we_q    <= mem_dm_we_d;
      mem_ret_q      <= mem_ret_d;
    end
  end

  assign MEM_valid      = mem_valid_q;
  assign MEM_ALU_RESULT = mem_res_q;
  assign MEM_DM_ADDR    = mem_addr_q;
  assign MEM_STORE_DATA = mem_store_q;
  assign MEM_NEXT_PC    = mem_npc_q;
  assign MEM_RF_D_SEL   = mem_rf_d_sel_q;
  assign MEM_RD_SEL     = mem_rd_sel_q;
  assign MEM_DM_WE      = mem_dm_we_q;
  assign MEM_ret_enable = mem_ret_q;

endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: arithmetic reference model of the EX/MEM contents checked every cycle,
// plus hand-computed literal expectations for the directed cases.
module tb_ex_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [4:0]  EX_ALU_OP;
  logic [31:0] EX_muxA, EX_muxB, EX_NEXT_PC;
  logic [15:0] EX_IMMEDIATE;
  logic [1:0]  EX_RF_D_SEL, EX_RD_SEL;
  logic        EX_DM_WE, EX_DM_ADDR_SEL, EX_ret_enable;
  logic        ex_stall, MEM_valid, MEM_DM_WE, MEM_ret_enable;
  logic [31:0] MEM_ALU_RESULT, MEM_DM_ADDR, MEM_STORE_DATA, MEM_NEXT_PC;
  logic [1:0]  MEM_RF_D_SEL, MEM_RD_SEL;

  ex_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .EX_ALU_OP(EX_ALU_OP),
    .EX_muxA(EX_muxA), .EX_muxB(EX_muxB), .EX_IMMEDIATE(EX_IMMEDIATE),
    .EX_NEXT_PC(EX_NEXT_PC), .EX_RF_D_SEL(EX_RF_D_SEL), .EX_RD_SEL(EX_RD_SEL),
    .EX_DM_WE(EX_DM_WE), .EX_DM_ADDR_SEL(EX_DM_ADDR_SEL), .EX_ret_enable(EX_ret_enable),
    .ex_stall(ex_stall), .MEM_valid(MEM_valid), .MEM_ALU_RESULT(MEM_ALU_RESULT),
    .MEM_DM_ADDR(MEM_DM_ADDR), .MEM_STORE_DATA(MEM_STORE_DATA), .MEM_NEXT_PC(MEM_NEXT_PC),
    .MEM_RF_D_SEL(MEM_RF_D_SEL), .MEM_RD_SEL(MEM_RD_SEL), .MEM_DM_WE(MEM_DM_WE),
    .MEM_ret_enable(MEM_ret_enable)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  // Expected EX/MEM contents and stall
  bit          exp_stall, exp_mv, exp_we, exp_ret;
  logic [31:0] exp_res, exp_addr, exp_store, exp_npc;
  logic [1:0]  exp_rf, exp_rd;
  logic [31:0] cap_a, cap_b;
  logic [31:0] pc_ctr = 32'h0000_1000;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit is_multi(input logic [4:0] op);
    return (op >= 5'd16) && (op <= 5'd19);
  endfunction

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b, input logic [15:0] i);
    logic [63:0] p;
    logic [31:0] se;
    p  = {32'h0, a} * {32'h0, b};
    se = {{16{i[15]}}, i};
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a & b;
      5'd3:  return a | b;
      5'd4:  return a ^ b;
      5'd5:  return a << b[4:0];
      5'd6:  return a >> b[4:0];
      5'd7:  return $unsigned($signed(a) >>> b[4:0]);
      5'd8:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd9:  return (a < b) ? 32'd1 : 32'd0;
      5'd10: return b;
      5'd11: return a + se;
      5'd16: return p[31:0];
      5'd17: return p[63:32];
      5'd18: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      5'd19: return (b == 0) ? a : a % b;
      default: return 32'h0;
    endcase
  endfunction

  task automatic clear_model();
    exp_stall = 0; exp_mv = 0; exp_we = 0; exp_ret = 0;
    exp_res = 0; exp_addr = 0; exp_store = 0; exp_npc = 0; exp_rf = 0; exp_rd = 0;
  endtask

  // What EX/MEM must hold after an edge, given the inputs presented during that cycle.
  task automatic model_update();
    logic [31:0] r;
    if (rst) clear_model();
    else if (exp_stall) begin
      exp_mv = 0;
      exp_we = 0;
    end else begin
      r = is_multi(EX_ALU_OP) ? ref_result(EX_ALU_OP, cap_a, cap_b, EX_IMMEDIATE)
                              : ref_result(EX_ALU_OP, EX_muxA, EX_muxB, EX_IMMEDIATE);
      exp_mv    = ex_valid;
      exp_res   = r;
      exp_addr  = EX_DM_ADDR_SEL ? {16'h0, EX_IMMEDIATE} : r;
      exp_store = EX_muxB;
      exp_npc   = EX_NEXT_PC;
      exp_rf    = EX_RF_D_SEL;
      exp_rd    = EX_RD_SEL;
      exp_we    = EX_DM_WE;
      exp_ret   = EX_ret_enable;
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("ex_stall", 64'(ex_stall), 64'(exp_stall));
      chk("MEM_valid", 64'(MEM_valid), 64'(exp_mv));
      chk("MEM_DM_WE", 64'(MEM_DM_WE), 64'(exp_we));
      if (exp_mv) begin
        chk("MEM_ALU_RESULT", 64'(MEM_ALU_RESULT), 64'(exp_res));
        chk("MEM_DM_ADDR", 64'(MEM_DM_ADDR), 64'(exp_addr));
        chk("MEM_STORE_DATA", 64'(MEM_STORE_DATA), 64'(exp_store));
        chk("MEM_NEXT_PC", 64'(MEM_NEXT_PC), 64'(exp_npc));
        chk("MEM_RF_D_SEL", 64'(MEM_RF_D_SEL), 64'(exp_rf));
        chk("MEM_RD_SEL", 64'(MEM_RD_SEL), 64'(exp_rd));
        chk("MEM_ret_enable", 64'(MEM_ret_enable), 64'(exp_ret));
      end
    end
  end

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] i, input logic sel, input logic we);
    ex_valid = 1; EX_ALU_OP = op; EX_muxA = a; EX_muxB = b; EX_IMMEDIATE = i;
    EX_DM_ADDR_SEL = sel; EX_DM_WE = we;
    EX_NEXT_PC = pc_ctr; pc_ctr += 4;
    EX_RF_D_SEL = pc_ctr[3:2]; EX_RD_SEL = op[1:0]; EX_ret_enable = op[0];
    cap_a = a; cap_b = b;
  endtask

  // Presents one instruction and walks it to completion (starts and ends at posedge+1).
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] i, input logic sel, input logic we, input bit scramble,
                       output int stalls, output bit we_leak);
    bit m;
    drive(op, a, b, i, sel, we);
    m = is_multi(op);
    stalls = 0; we_leak = 0;
    for (int k = 0; k < (m ? 34 : 1); k++) begin
      exp_stall = m && (k < 33);
      @(negedge clk);
      if (ex_stall) stalls++;
      if (k >= 1 && k <= 33 && MEM_DM_WE) we_leak = 1;
      @(posedge clk);
      model_update();
      if (scramble && k == 1) begin
        #1;
        EX_muxA = ~EX_muxA;
        EX_muxB = 32'hDEAD_BEEF;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    ex_valid = 0;
    for (int k = 0; k < n; k++) begin
      exp_stall = 0;
      @(negedge clk);
      @(posedge clk);
      model_update();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    int  st;
    bit  leak;
    rst = 1; ex_valid = 0; EX_ALU_OP = 0; EX_muxA = 0; EX_muxB = 0; EX_IMMEDIATE = 0;
    EX_NEXT_PC = 0; EX_RF_D_SEL = 0; EX_RD_SEL = 0; EX_DM_WE = 0; EX_DM_ADDR_SEL = 0;
    EX_ret_enable = 0; cap_a = 0; cap_b = 0;
    clear_model();
    #1;
    chk("reset_valid", 64'(MEM_valid), 64'd0);
    chk("reset_result", 64'(MEM_ALU_RESULT), 64'd0);
    chk("reset_stall", 64'(ex_stall), 64'd0);
    @(posedge clk); #1;
    rst = 0;
    chk_on = 1;
    idle(2);

    issue(5'd0, 32'hFFFF_FFFF, 32'h1, 16'h0, 0, 0, 0, st, leak);
    chk("add_wrap", 64'(MEM_ALU_RESULT), 64'h0);
    chk("add_valid", 64'(MEM_valid), 64'd1);
    issue(5'd7, 32'h8000_0000, 32'h4, 16'h0, 0, 0, 0, st, leak);
    chk("sra", 64'(MEM_ALU_RESULT), 64'hF800_0000);
    issue(5'd11, 32'h5, 32'h0, 16'hFFFF, 0, 0, 0, st, leak);
    chk("addi_neg", 64'(MEM_ALU_RESULT), 64'h4);
    issue(5'd1, 32'h3, 32'h5, 16'h0, 0, 0, 0, st, leak);
    chk("sub", 64'(MEM_ALU_RESULT), 64'hFFFF_FFFE);
    issue(5'd8, 32'hFFFF_FFFF, 32'h1, 16'h0, 0, 0, 0, st, leak);
    chk("slt", 64'(MEM_ALU_RESULT), 64'h1);
    issue(5'd9, 32'hFFFF_FFFF, 32'h1, 16'h0, 0, 0, 0, st, leak);
    chk("sltu", 64'(MEM_ALU_RESULT), 64'h0);
    issue(5'd5, 32'h1, 32'd35, 16'h0, 0, 0, 0, st, leak);
    chk("sll", 64'(MEM_ALU_RESULT), 64'h8);
    issue(5'd6, 32'hF000_0000, 32'd28, 16'h0, 0, 0, 0, st, leak);
    issue(5'd4, 32'hFF00_FF00, 32'h0FF0_0FF0, 16'h0, 0, 0, 0, st, leak);
    issue(5'd10, 32'h1, 32'hCAFE_F00D, 16'h0, 0, 0, 0, st, leak);
    issue(5'd20, 32'h1, 32'h2, 16'h0, 0, 0, 0, st, leak);
    chk("undef_op", 64'(MEM_ALU_RESULT), 64'h0);

    issue(5'd16, 32'h0001_0000, 32'h0001_0000, 16'h0, 0, 0, 0, st, leak);
    chk("mul_stall_cycles", 64'(st), 64'd33);
    chk("mul_low", 64'(MEM_ALU_RESULT), 64'h0);
    chk("mul_valid", 64'(MEM_valid), 64'd1);
    issue(5'd17, 32'h0001_0000, 32'h0001_0000, 16'h0, 0, 0, 0, st, leak);
    chk("mulhu", 64'(MEM_ALU_RESULT), 64'h1);
    issue(5'd18, 32'd100, 32'd7, 16'h0, 0, 0, 0, st, leak);
    chk("divu", 64'(MEM_ALU_RESULT), 64'd14);
    chk("div_stall_cycles", 64'(st), 64'd33);
    issue(5'd19, 32'd100, 32'd7, 16'h0, 0, 0, 0, st, leak);
    chk("remu", 64'(MEM_ALU_RESULT), 64'd2);
    issue(5'd18, 32'h1234, 32'h0, 16'h0, 0, 0, 0, st, leak);
    chk("divu_by0", 64'(MEM_ALU_RESULT), 64'hFFFF_FFFF);
    chk("divu_by0_stall", 64'(st), 64'd33);
    issue(5'd19, 32'h1234, 32'h0, 16'h0, 0, 0, 0, st, leak);
    chk("remu_by0", 64'(MEM_ALU_RESULT), 64'h1234);
    issue(5'd18, 32'd1000, 32'd10, 16'h0, 0, 0, 1, st, leak);
    chk("divu_operands_held", 64'(MEM_ALU_RESULT), 64'd100);
    issue(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'h0, 0, 0, 0, st, leak);
    chk("mulhu_max", 64'(MEM_ALU_RESULT), 64'hFFFF_FFFE);

    issue(5'd0, 32'h10, 32'h20, 16'h00F0, 1, 1, 0, st, leak);
    chk("store_addr", 64'(MEM_DM_ADDR), 64'h0000_00F0);
    chk("store_we", 64'(MEM_DM_WE), 64'd1);
    issue(5'd16, 32'd3, 32'd4, 16'h00F0, 1, 1, 0, st, leak);
    chk("store_we_in_stall", 64'(leak), 64'd0);
    chk("store_after_stall_we", 64'(MEM_DM_WE), 64'd1);
    chk("mul_small", 64'(MEM_ALU_RESULT), 64'd12);

    // Mid-cycle reset with nonzero EX/MEM contents
    #2;
    ex_valid = 0; rst = 1;
    clear_model();
    #1;
    chk("rst_mid_result", 64'(MEM_ALU_RESULT), 64'h0);
    chk("rst_mid_addr", 64'(MEM_DM_ADDR), 64'h0);
    chk("rst_mid_npc", 64'(MEM_NEXT_PC), 64'h0);
    chk("rst_mid_we", 64'(MEM_DM_WE), 64'd0);
    chk("rst_mid_stall", 64'(ex_stall), 64'd0);
    @(posedge clk); model_update(); #1;
    rst = 0;
    idle(1);

    // Reset while the unit is at iteration count 10
    drive(5'd16, 32'd7, 32'd9, 16'h0, 0, 0);
    for (int k = 0; k <= 10; k++) begin
      exp_stall = 1;
      @(negedge clk);
      @(posedge clk);
      model_update();
    end
    #2;
    chk("busy_stall_before_rst", 64'(ex_stall), 64'd1);
    ex_valid = 0; rst = 1;
    clear_model();
    #1;
    chk("abort_stall", 64'(ex_stall), 64'd0);
    chk("abort_valid", 64'(MEM_valid), 64'd0);
    @(posedge clk); model_update(); #1;
    rst = 0;
    idle(4);
    chk("abort_no_pulse", 64'(MEM_valid), 64'd0);
    issue(5'd0, 32'd2, 32'd3, 16'h0, 0, 0, 0, st, leak);
    chk("add_after_abort", 64'(MEM_ALU_RESULT), 64'd5);
    chk("add_after_abort_valid", 64'(MEM_valid), 64'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 32-bit pipeline. It consumes the operands and control fields registered by the ID/EX pipeline register, computes single-cycle ALU results, and runs an iterative multiply/divide unit that stalls the front of the pipeline. It drives the EX/MEM pipeline register, which is built into this block.

## Interface
Parameters:
- XLEN, 32, datapath width.
- MD_CYCLES, 32, iteration count of the multiply/divide unit. Must equal XLEN.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  an instruction is held in ID/EX.
- EX_ALU_OP  in  5  operation code.
- EX_muxA, EX_muxB  in  32  operands A and B.
- EX_IMMEDIATE  in  16  immediate field.
- EX_NEXT_PC  in  32  PC+4 of the instruction.
- EX_RF_D_SEL  in  2  control field, passed through to MEM.
- EX_RD_SEL  in  2  control field, passed through to MEM.
- EX_DM_WE  in  1  control field, passed through to MEM.
- EX_DM_ADDR_SEL  in  1  data-memory address select.
- EX_ret_enable  in  1  control field, passed through to MEM.
- ex_stall  out  1  holds the PC, IF/ID and ID/EX registers while high.
- MEM_valid  out  1  the EX/MEM register holds a real instruction.
- MEM_ALU_RESULT  out  32  registered result.
- MEM_DM_ADDR  out  32  registered data-memory address.
- MEM_STORE_DATA  out  32  registered operand B.
- MEM_NEXT_PC  out  32  registered EX_NEXT_PC.
- MEM_RF_D_SEL, MEM_RD_SEL, MEM_DM_WE, MEM_ret_enable  out  2/2/1/1  registered copies of the control fields.

## Operation
- Single-cycle opcodes. All arithmetic wraps modulo 2^32. No flags are produced.
  - 0 ADD: A+B.
  - 1 SUB: A−B.
  - 2 AND, 3 OR, 4 XOR.
  - 5 SLL: A<<B[4:0].
  - 6 SRL: logical right shift.
  - 7 SRA: arithmetic right shift.
  - 8 SLT: signed A<B, result 1 or 0.
  - 9 SLTU: unsigned A<B, result 1 or 0.
  - 10 PASSB: B.
  - 11 ADDI: A + sign-extended immediate.
- Multi-cycle opcodes (unsigned):
  - 16 MUL: low 32 bits of the product.
  - 17 MULHU: high 32 bits of the product.
  - 18 DIVU: quotient.
  - 19 REMU: remainder.
- Any other opcode gives result 0.
- Multiply uses shift-add with a 64-bit accumulator. Divide uses restoring division, one bit per cycle.
- Divide by zero: DIVU returns 0xFFFFFFFF and REMU returns A. The unit still takes the full iteration count.
- MEM_DM_ADDR is {16'h0, EX_IMMEDIATE} when EX_DM_ADDR_SEL=1, otherwise the ALU result.
- MD state machine:
  - IDLE: if ex_valid and the opcode is multi-cycle, capture the operands and go to BUSY with count=0.
  - BUSY: one iteration per cycle. When count=MD_CYCLES−1, go to DONE.
  - DONE: the result is presented to the EX/MEM register. Return to IDLE on the next edge.
- ex_stall = (IDLE & ex_valid & multi-cycle op) | BUSY. It is combinational. ex_stall is low in DONE, so ID/EX advances on the same edge that MEM captures the result.
- EX/MEM update on every edge:
  - While ex_stall=1: MEM_valid←0 and MEM_DM_WE←0 (bubble). The other MEM fields may hold.
  - Otherwise: all MEM fields load, and MEM_valid←ex_valid.
- An instruction with ex_valid=0 never starts the MD unit.

## Timing
- Reset (asynchronous, takes effect immediately):
  - All MEM_* outputs go to 0.
  - The state machine goes to IDLE and count to 0.
  - ex_stall falls combinationally once the state is IDLE.
- Single-cycle op: the result appears on MEM_* one edge after it is presented.
- Multi-cycle op:
  - Present in ID/EX at cycle 0.
  - ex_stall is high for cycles 0–32 (33 cycles).
  - DONE in cycle 33. The result appears on MEM_* after the edge ending cycle 33.
- Reset during BUSY aborts the operation. No result is written and MEM_valid stays 0.
- Back-to-back multi-cycle ops: the second starts from IDLE in the cycle after DONE, with no overlap.
- Changes to operand inputs during BUSY are ignored, because operands are captured at start.

## Test plan
- Reset: assert rst mid-cycle with MEM_* nonzero -> all outputs 0 immediately and ex_stall=0.
- ADD 0xFFFFFFFF+0x1 -> MEM_ALU_RESULT=0x0 one edge later with MEM_valid=1. SRA 0x80000000 by 4 -> 0xF8000000. ADDI A=5, imm=0xFFFF -> 4.
- MUL and MULHU with 0x00010000×0x00010000 -> low result 0x0, high result 0x1. ex_stall high for exactly 33 cycles, then the result arrives after the next edge, with MEM_valid=0 throughout the stall.
- DIVU/REMU 100÷7 -> 14 and 2. Divide by zero with A=0x1234 -> DIVU 0xFFFFFFFF, REMU 0x1234.
- Reset asserted at BUSY count 10 -> IDLE, no MEM_valid pulse. A new ADD issued afterwards completes normally.
- EX_DM_ADDR_SEL=1, imm=0x00F0, EX_DM_WE=1 -> MEM_DM_ADDR=0x000000F0 and MEM_DM_WE=1. The same store issued during a stall -> MEM_DM_WE=0.
